mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 12, width of one memory word.
REQ-002 Parameter DEPTH, default 4096, number of memory locations.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), memory address width.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 num_words  input  ADDR_WIDTH+1  words to load; latched on accepted start.
REQ-008 rx_data  input  8  incoming byte.
REQ-009 rx_valid  input  1  rx_data valid this cycle.
REQ-010 rx_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_wrEn  output  1  write strobe to instruction memory.
REQ-012 mem_address  output  ADDR_WIDTH  write address.
REQ-013 mem_dataIn  output  DATA_WIDTH  write data.
REQ-014 busy  output  1  high from accepted start until DONE is left.
REQ-015 done  output  1  one-cycle pulse when the load completes.

Function
REQ-016 States: IDLE, RECV, WRITE, DONE; the state register shall be the only control state besides the counters below.
REQ-017 BYTES_PER_WORD shall equal ceil(DATA_WIDTH/8) (2 at default).
REQ-018 IDLE: if start=1, latch num_words and clear word and byte counters; go to DONE if num_words=0, else RECV.
REQ-019 RECV: rx_ready=1; a byte is accepted only on rx_valid&rx_ready.
REQ-020 Bytes are little-endian: byte k fills bits [8k+7:8k]; bits above DATA_WIDTH-1 are discarded (upper nibble of byte 1 at default).
REQ-021 On acceptance of byte BYTES_PER_WORD-1: go to WRITE next cycle; byte counter back to 0.
REQ-022 WRITE: mem_wrEn=1 for exactly one cycle, mem_address=word counter, mem_dataIn=assembled word; rx_ready=0.
REQ-023 After WRITE: increment word counter; if incremented value equals latched num_words go to DONE, else RECV.
REQ-024 Per-word latency: one WRITE cycle after the last byte's acceptance cycle; throughput BYTES_PER_WORD+1 cycles per word minimum.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy=1 in RECV, WRITE, DONE.
REQ-026 num_words greater than DEPTH shall be clamped to DEPTH; address never wraps.
REQ-027 start while not in IDLE shall be ignored; num_words changes after latch shall be ignored.
REQ-028 rx_valid while rx_ready=0 shall not consume the byte (source holds it).
REQ-029 mem_wrEn shall be 0 in every state except WRITE; mem_address/mem_dataIn hold last values otherwise.

Reset
REQ-030 rst=1 at posedge: state IDLE, counters 0, assembly register 0, all outputs 0, regardless of state (a partial load is abandoned; no further writes).
REQ-031 rst takes priority over start and rx_valid in the same cycle.

Structure
REQ-032 State encoding and BYTES_PER_WORD calculation shall live in the shared package with the memory width constants.
REQ-033 Single flat module; no sub-module; instantiated beside insMem, driving its wrEn/address/dataIn.

Verification
REQ-034 num_words=2, bytes 0x34,0x12,0xCD,0xFB back-to-back -> writes addr0=0x234, addr1=0xBCD; done pulses once; busy then low.
REQ-035 num_words=0 with start -> DONE next cycle, done pulse, mem_wrEn never asserted.
REQ-036 rx_valid toggling 1/0 per cycle, num_words=3 -> exactly 3 writes, addresses 0,1,2, no byte lost or duplicated.
REQ-037 rst asserted after first byte of word 1 -> outputs 0 next cycle, no write to addr1; new start then loads from addr0.
REQ-038 start pulsed during RECV with different num_words -> ignored; original count completes.
REQ-039 num_words=DEPTH+1 at DEPTH=8 -> exactly 8 writes, last address 7, then done.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared constants, state encoding and word-geometry helpers for the
// byte-stream memory loader and the instruction memory it feeds.
package mem_loader_pkg;

    // Default instruction memory geometry.
    localparam int MEM_DATA_WIDTH = 12;
    localparam int MEM_DEPTH      = 4096;
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    // Number of incoming bytes needed to build one memory word.
    function automatic int bytes_per_word(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    // Width of a counter that indexes bytes within one word (at least 1 bit).
    function automatic int byte_cnt_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Byte-stream memory loader: assembles little-endian bytes into memory words
// and writes them to consecutive addresses starting at 0. Sits beside the
// instruction memory and drives its wrEn/address/dataIn.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_wrEn,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    output logic                  busy,
    output logic                  done
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int BCW   = byte_cnt_width(BPW);
    localparam int ASM_W = BPW * 8;

    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);

    ld_state_e             state_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [BCW-1:0]        byte_cnt_q;
    logic [ASM_W-1:0]      asm_q;
    logic                  rx_ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;

    logic [ADDR_WIDTH:0]   word_cnt_d;
    logic [ADDR_WIDTH:0]   num_d;
    logic [ASM_W-1:0]      asm_d;
    logic                  accept_s;
    logic                  byte_last_s;

    // Next-value helpers: word increment, clamped count, byte insertion, handshake.
    always_comb begin
        word_cnt_d  = word_cnt_q + (ADDR_WIDTH + 1)'(1);
        num_d       = (num_words > DEPTH_C) ? DEPTH_C : num_words;
        asm_d       = asm_q;
        asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
        accept_s    = rx_valid & rx_ready_q;
        byte_last_s = (byte_cnt_q == LAST_BYTE);
    end

    // Loader FSM with counters, assembly register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            num_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        num_q      <= num_d;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        asm_q      <= '0;
                        busy_q     <= 1'b1;
                        if (num_d == '0) begin
                            // Empty load: report completion immediately.
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end else begin
                            state_q    <= ST_RECV;
                            rx_ready_q <= 1'b1;
                        end
                    end else begin
                        state_q    <= ST_IDLE;
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        asm_q <= asm_d;
                        if (byte_last_s) begin
                            // Word complete: present it to memory next cycle.
                            byte_cnt_q <= '0;
                            state_q    <= ST_WRITE;
                            rx_ready_q <= 1'b0;
                            wr_en_q    <= 1'b1;
                            addr_q     <= word_cnt_q[ADDR_WIDTH-1:0];
                            data_q     <= asm_d[DATA_WIDTH-1:0];
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end else begin
                        state_q <= ST_RECV;
                    end
                end
                ST_WRITE: begin
                    wr_en_q    <= 1'b0;
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_d == num_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_RECV;
                        rx_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                    wr_en_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_wrEn    = wr_en_q;
    assign mem_address = addr_q;
    assign mem_dataIn  = data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader (12-bit words, 8-entry memory).
// Expected writes are derived from the byte stream: word i is made of bytes
// 2i (low) and 2i+1 (low nibble on top), count clamped to the memory depth.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_words;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_wrEn;
    logic [2:0]  mem_address;
    logic [11:0] mem_dataIn;
    logic        busy;
    logic        done;

    mem_loader #(.DATA_WIDTH(12), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_wrEn(mem_wrEn), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int num;     // num_words driven with start
        int mode;    // 0: valid every cycle, 1: toggling, 2: random
        int glitch;  // loop cycle at which a stray start is pulsed (-1: none)
        int expw;    // writes expected
    } vec_t;

    logic [7:0]  bq[$];
    logic [2:0]  wa[$];
    logic [11:0] wd[$];
    int bidx, blimit, vmode, done_cnt, cyc, last_acc;
    int n_vec = 0;
    int n_err = 0;
    bit tog;

    task automatic compare(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic tick();
        bit v;
        @(negedge clk);
        cyc++;
        if (mem_wrEn) begin
            wa.push_back(mem_address);
            wd.push_back(mem_dataIn);
            compare("write_latency", cyc, last_acc + 1);
            compare("ready_during_write", int'(rx_ready), 0);
        end
        if (done) done_cnt++;
        start     = 1'b0;
        num_words = 4'($urandom);
        case (vmode)
            0:       v = 1'b1;
            1:       begin v = tog; tog = ~tog; end
            default: v = 1'($urandom_range(0, 1));
        endcase
        if (v && bidx < blimit) begin
            rx_valid = 1'b1;
            rx_data  = bq[bidx];
            if (rx_ready) begin
                bidx++;
                last_acc = cyc;
            end
        end else begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic fill_random(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    endtask

    task automatic check_writes(input string tag, input int expw);
        compare({tag, "_write_count"}, wa.size(), expw);
        for (int i = 0; i < wa.size() && i < expw; i++) begin
            compare({tag, "_addr"}, int'(wa[i]), i);
            compare({tag, "_data"}, int'(wd[i]), int'({bq[2*i+1][3:0], bq[2*i]}));
        end
    endtask

    // Full load using bytes already in bq; checks completion and every write.
    task automatic load(input int num, input int mode, input int glitch,
                        input int expw, input string tag);
        vmode = mode; bidx = 0; blimit = 2 * expw; tog = 1'b1;
        wa.delete(); wd.delete(); done_cnt = 0;
        start = 1'b1; num_words = 4'(num);
        tick();
        compare({tag, "_busy_after_start"}, int'(busy), 1);
        if (num == 0) compare({tag, "_done_next_cycle"}, int'(done), 1);
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            if (c == glitch) begin
                start = 1'b1;
                num_words = 4'((num + 3) % 16);
            end
            tick();
        end
        if (done_cnt == 0) compare({tag, "_timeout"}, 0, 1);
        tick();
        compare({tag, "_busy_low_after_done"}, int'(busy), 0);
        compare({tag, "_done_one_cycle"}, int'(done), 0);
        repeat (3) tick();
        compare({tag, "_done_pulses"}, done_cnt, 1);
        check_writes(tag, expw);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; start = 1'b0; num_words = 4'd0;
        rx_data = 8'd0; rx_valid = 1'b0;
        cyc = 0; last_acc = -10; vmode = 0; bidx = 0; blimit = 0; tog = 1'b1;
        done_cnt = 0;

        // Reset state.
        tick(); tick();
        compare("rst_rx_ready", int'(rx_ready), 0);
        compare("rst_busy", int'(busy), 0);
        compare("rst_done", int'(done), 0);
        compare("rst_wren", int'(mem_wrEn), 0);
        compare("rst_addr", int'(mem_address), 0);
        compare("rst_data", int'(mem_dataIn), 0);
        rst = 1'b0;
        tick();

        // Known-answer load: 0x34,0x12,0xCD,0xFB -> 0x234 @0, 0xBCD @1.
        bq.delete();
        bq.push_back(8'h34); bq.push_back(8'h12);
        bq.push_back(8'hCD); bq.push_back(8'hFB);
        load(2, 0, -1, 2, "kat");
        if (wd.size() >= 2) begin
            compare("kat_word0", int'(wd[0]), 12'h234);
            compare("kat_word1", int'(wd[1]), 12'hBCD);
        end else begin
            compare("kat_word_presence", wd.size(), 2);
        end

        // Table of loads with random byte data.
        vecs.push_back('{num: 0,  mode: 0, glitch: -1, expw: 0});
        vecs.push_back('{num: 3,  mode: 1, glitch: -1, expw: 3});
        vecs.push_back('{num: 9,  mode: 0, glitch: -1, expw: 8});
        vecs.push_back('{num: 2,  mode: 2, glitch: 3,  expw: 2});
        vecs.push_back('{num: 1,  mode: 0, glitch: -1, expw: 1});
        vecs.push_back('{num: 8,  mode: 2, glitch: -1, expw: 8});
        vecs.push_back('{num: 15, mode: 2, glitch: 5,  expw: 8});
        vecs.push_back('{num: 5,  mode: 1, glitch: 2,  expw: 5});
        foreach (vecs[i]) begin
            fill_random(2 * vecs[i].expw);
            load(vecs[i].num, vecs[i].mode, vecs[i].glitch, vecs[i].expw,
                 $sformatf("vec%0d", i));
        end

        // Reset in the middle of word 1 abandons the load.
        fill_random(4);
        vmode = 0; bidx = 0; blimit = 3; tog = 1'b1;
        wa.delete(); wd.delete(); done_cnt = 0;
        start = 1'b1; num_words = 4'd2;
        for (int c = 0; c < 50 && bidx < 3; c++) tick();
        compare("midrst_bytes_offered", bidx, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        compare("midrst_rx_ready", int'(rx_ready), 0);
        compare("midrst_busy", int'(busy), 0);
        compare("midrst_wren", int'(mem_wrEn), 0);
        compare("midrst_addr", int'(mem_address), 0);
        compare("midrst_data", int'(mem_dataIn), 0);
        blimit = 4;
        repeat (10) tick();
        compare("midrst_writes", wa.size(), 1);
        compare("midrst_done", done_cnt, 0);
        compare("midrst_byte_held", bidx, 3);
        fill_random(2);
        load(1, 0, -1, 1, "after_rst");

        // Reset wins over a simultaneous start.
        blimit = 0;
        rst = 1'b1; start = 1'b1; num_words = 4'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        tick();
        compare("rst_vs_start_busy", int'(busy), 0);
        compare("rst_vs_start_ready", int'(rx_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
